// File: rtl/kronos_types.sv
// ============================================================================
// Module   : kronos_types
// Brief    : Shared types and constants for the Kronos memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package kronos_types;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_I = 2'd1,
      OWN_D = 2'd2
   } arb_owner_e;

   localparam int ARB_STARVE_W = 8;

endpackage

`default_nettype wire

// File: rtl/kronos_mem_arb.sv
// ============================================================================
// Module   : kronos_mem_arb
// Brief    : Fetch/load-store arbiter for one memory bus, data-priority with
//            ownership lock; fairness counter enabled by KRONOS_ARB_FAIRNESS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module kronos_mem_arb
   import kronos_types::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic [31:0] instr_addr,
   input  logic        instr_req,
   output logic [31:0] instr_data,
   output logic        instr_gnt,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_mask,
   input  logic        data_wr_en,
   input  logic        data_req,
   output logic [31:0] data_rdata,
   output logic        data_ack,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_mask,
   output logic        mem_wr_en,
   output logic        mem_req,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("kronos_mem_arb: STARVE_LIMIT must be in 1..255");
   end

   arb_owner_e r_state;
   arb_owner_e w_state_nxt;
   logic       w_sel_i;
   logic       w_sel_d;
   logic       w_starved;

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_sel_i     = 1'b0;
      w_sel_d     = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (data_req && !w_starved) w_sel_d = 1'b1;
            else if (instr_req)         w_sel_i = 1'b1;
            if (w_sel_d && !mem_ack)      w_state_nxt = OWN_D;
            else if (w_sel_i && !mem_ack) w_state_nxt = OWN_I;
         end
         OWN_I: begin
            w_sel_i = 1'b1;
            if (mem_ack || !instr_req) w_state_nxt = IDLE;
         end
         OWN_D: begin
            w_sel_d = 1'b1;
            if (mem_ack || !data_req) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      // Keep the bus quiet while reset is held, even with requests pending.
      if (!rstz) begin
         w_sel_i = 1'b0;
         w_sel_d = 1'b0;
      end
   end

   assign mem_addr  = w_sel_d ? data_addr  : (w_sel_i ? instr_addr : 32'h0);
   assign mem_wdata = w_sel_d ? data_wdata : 32'h0;
   assign mem_mask  = w_sel_d ? data_mask  : 4'h0;
   assign mem_wr_en = w_sel_d & data_wr_en;
   assign mem_req   = (w_sel_d & data_req) | (w_sel_i & instr_req);

   assign instr_gnt  = mem_ack & w_sel_i;
   assign data_ack   = mem_ack & w_sel_d;
   assign instr_data = mem_rdata;
   assign data_rdata = mem_rdata;

`ifdef KRONOS_ARB_FAIRNESS_EN
   localparam logic [ARB_STARVE_W-1:0] c_limit = ARB_STARVE_W'(STARVE_LIMIT);

   logic [ARB_STARVE_W-1:0] r_starve_cnt;

   // Counts data wins that happened while fetch was waiting; saturates.
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz)
         r_starve_cnt <= '0;
      else if (!instr_req || instr_gnt)
         r_starve_cnt <= '0;
      else if (data_ack && (r_starve_cnt != '1))
         r_starve_cnt <= r_starve_cnt + 1'b1;
   end

   assign w_starved = (r_starve_cnt >= c_limit);
`else
   assign w_starved = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kronos_mem_arb.sv
// ============================================================================
// Module   : tb_kronos_mem_arb
// Brief    : Self-checking bench for kronos_mem_arb with an acknowledge
//            scoreboard; expectations follow KRONOS_ARB_FAIRNESS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_kronos_mem_arb;
   import kronos_types::*;

   localparam int unsigned STARVE_LIMIT = 4;
`ifdef KRONOS_ARB_FAIRNESS_EN
   localparam bit c_fair = 1'b1;
`else
   localparam bit c_fair = 1'b0;
`endif
   localparam logic [1:0] c_side_i = 2'b10;
   localparam logic [1:0] c_side_d = 2'b01;

   logic        clk = 1'b0;
   logic        rstz = 1'b0;
   logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
   logic        instr_req, data_req, data_wr_en, mem_ack;
   logic [3:0]  data_mask;
   logic [31:0] instr_data, data_rdata, mem_addr, mem_wdata;
   logic        instr_gnt, data_ack, mem_wr_en, mem_req;
   logic [3:0]  mem_mask;

   kronos_mem_arb #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk        (clk),
      .rstz       (rstz),
      .instr_addr (instr_addr),
      .instr_req  (instr_req),
      .instr_data (instr_data),
      .instr_gnt  (instr_gnt),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_mask  (data_mask),
      .data_wr_en (data_wr_en),
      .data_req   (data_req),
      .data_rdata (data_rdata),
      .data_ack   (data_ack),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_mask   (mem_mask),
      .mem_wr_en  (mem_wr_en),
      .mem_req    (mem_req),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  side;
      logic [31:0] addr;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_ack(input logic [1:0] side, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.side  = side;
      e.addr  = a;
      e.rdata = d;
      sb_q.push_back(e);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr_addr = '0; instr_req = 1'b0;
      data_addr  = '0; data_wdata = '0; data_mask = '0;
      data_wr_en = 1'b0; data_req = 1'b0;
      mem_rdata  = '0; mem_ack = 1'b0;
   endtask

   // Every acknowledge seen on the bus must match the oldest expected entry.
   always @(negedge clk) begin : sb_monitor
      exp_t e;
      if (instr_gnt || data_ack) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", {62'd0, instr_gnt, data_ack}, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_side", {62'd0, instr_gnt, data_ack}, {62'd0, e.side});
            chk("sb_addr", {32'd0, mem_addr}, {32'd0, e.addr});
            chk("sb_rdata", {32'd0, (instr_gnt ? instr_data : data_rdata)}, {32'd0, e.rdata});
         end
      end
   end

   // Both requesters busy, ack every cycle; fetch wins every fifth slot when fair.
   task automatic run_fair(input int n);
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         next_cyc();
         d          = $urandom;
         instr_req  = 1'b1; instr_addr = 32'h500 + 32'(i * 4);
         data_req   = 1'b1; data_addr  = 32'h5000 + 32'(i * 4);
         data_wr_en = 1'b0; mem_ack = 1'b1; mem_rdata = d;
         if (c_fair && (i % 5 == 4)) expect_ack(c_side_i, instr_addr, d);
         else                        expect_ack(c_side_d, data_addr, d);
         @(negedge clk);
         chk("fair_req", {63'd0, mem_req}, 64'd1);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      idle_inputs();
      @(negedge clk);
      chk("rst_req",   {63'd0, mem_req},   64'd0);
      chk("rst_wr",    {63'd0, mem_wr_en}, 64'd0);
      chk("rst_igatn", {63'd0, instr_gnt}, 64'd0);
      chk("rst_dack",  {63'd0, data_ack},  64'd0);
      chk("rst_state", {62'd0, dut.r_state}, {62'd0, IDLE});
      next_cyc();
      rstz = 1'b1;

      // Fetch only, single-cycle completion
      next_cyc();
      instr_req = 1'b1; instr_addr = 32'h100; data_wdata = 32'hFFFF_FFFF;
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      expect_ack(c_side_i, 32'h100, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("f_addr",  {32'd0, mem_addr},   64'h100);
      chk("f_req",   {63'd0, mem_req},    64'd1);
      chk("f_wr",    {63'd0, mem_wr_en},  64'd0);
      chk("f_wdata", {32'd0, mem_wdata},  64'd0);
      chk("f_idata", {32'd0, instr_data}, 64'hDEAD_BEEF);
      next_cyc();
      idle_inputs();
      @(negedge clk);
      chk("f_state", {62'd0, dut.r_state}, {62'd0, IDLE});

      // Conflict: store wins and holds the bus until its delayed ack
      next_cyc();
      instr_req = 1'b1; instr_addr = 32'h104;
      data_req = 1'b1; data_addr = 32'h2000; data_wr_en = 1'b1;
      data_wdata = 32'h1234_5678; data_mask = 4'hF; mem_rdata = 32'h0000_1111;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) next_cyc();
         mem_ack = (c == 2);
         if (c == 2) expect_ack(c_side_d, 32'h2000, 32'h0000_1111);
         @(negedge clk);
         chk("cf_addr",  {32'd0, mem_addr},  64'h2000);
         chk("cf_wr",    {63'd0, mem_wr_en}, 64'd1);
         chk("cf_wdata", {32'd0, mem_wdata}, 64'h1234_5678);
         chk("cf_ignt",  {63'd0, instr_gnt}, 64'd0);
      end
      next_cyc();
      data_req = 1'b0; data_wr_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
      expect_ack(c_side_i, 32'h104, 32'hCAFE_0001);
      @(negedge clk);
      chk("cf_next_addr", {32'd0, mem_addr}, 64'h104);
      chk("cf_next_wr",   {63'd0, mem_wr_en}, 64'd0);
      chk("cf_next_mask", {60'd0, mem_mask},  64'd0);
      next_cyc();
      idle_inputs();

      // Lock: fetch keeps the bus while a load arrives
      next_cyc();
      instr_req = 1'b1; instr_addr = 32'h200; mem_rdata = 32'h0000_2222;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) next_cyc();
         if (c == 1) begin data_req = 1'b1; data_addr = 32'h3000; data_wr_en = 1'b0; end
         mem_ack = (c == 3);
         if (c == 3) expect_ack(c_side_i, 32'h200, 32'h0000_2222);
         @(negedge clk);
         chk("lk_addr", {32'd0, mem_addr}, 64'h200);
         chk("lk_dack", {63'd0, data_ack}, 64'd0);
      end
      next_cyc();
      instr_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_3333;
      expect_ack(c_side_d, 32'h3000, 32'h0000_3333);
      @(negedge clk);
      chk("lk_next_addr", {32'd0, mem_addr}, 64'h3000);
      chk("lk_next_wr",   {63'd0, mem_wr_en}, 64'd0);
      next_cyc();
      idle_inputs();

      // Withdrawal: fetch drops its request while owning the bus
      next_cyc();
      instr_req = 1'b1; instr_addr = 32'h400;
      @(negedge clk);
      chk("wd_addr0", {32'd0, mem_addr}, 64'h400);
      next_cyc();
      data_req = 1'b1; data_addr = 32'h4000; data_wr_en = 1'b1;
      data_wdata = 32'h0BAD_F00D; data_mask = 4'hC;
      @(negedge clk);
      chk("wd_addr1", {32'd0, mem_addr},  64'h400);
      chk("wd_wr1",   {63'd0, mem_wr_en}, 64'd0);
      next_cyc();
      instr_req = 1'b0;
      @(negedge clk);
      chk("wd_req",  {63'd0, mem_req},   64'd0);
      chk("wd_ignt", {63'd0, instr_gnt}, 64'd0);
      next_cyc();
      mem_ack = 1'b1; mem_rdata = 32'h0000_4444;
      expect_ack(c_side_d, 32'h4000, 32'h0000_4444);
      @(negedge clk);
      chk("wd_state", {62'd0, dut.r_state}, {62'd0, IDLE});
      chk("wd_addr",  {32'd0, mem_addr},  64'h4000);
      chk("wd_mask",  {60'd0, mem_mask},  64'hC);
      next_cyc();
      idle_inputs();

      // Fairness pattern over two full rounds
      run_fair(10);
      next_cyc();
      idle_inputs();

      // Reset in the middle of a data transaction, with a partly built count
      run_fair(2);
      next_cyc();
      data_addr = 32'h6000; data_wr_en = 1'b1; data_wdata = 32'hA5A5_A5A5;
      data_mask = 4'h3; mem_ack = 1'b0;
      @(negedge clk);
      chk("rs_addr", {32'd0, mem_addr}, 64'h6000);
      next_cyc();
      @(negedge clk);
      chk("rs_own", {62'd0, dut.r_state}, {62'd0, OWN_D});
      #2 rstz = 1'b0;
      #1;
      chk("rs_req",   {63'd0, mem_req},  64'd0);
      chk("rs_dack",  {63'd0, data_ack}, 64'd0);
      chk("rs_state", {62'd0, dut.r_state}, {62'd0, IDLE});
      next_cyc();
      @(negedge clk);
      chk("rs_req_hold", {63'd0, mem_req}, 64'd0);
      next_cyc();
      rstz = 1'b1; data_wr_en = 1'b0;
      @(negedge clk);
      chk("rs_rel_req",  {63'd0, mem_req},  64'd1);
      chk("rs_rel_dack", {63'd0, data_ack}, 64'd0);
      run_fair(5);
      next_cyc();
      idle_inputs();

      @(negedge clk);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      chk("end_req", {63'd0, mem_req}, 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/kronos_mem_arb.md
# kronos_mem_arb

Two-requester arbiter that shares one single-ported memory bus between the instruction-fetch port and the load/store data port of the Kronos core. Each transaction is a request/acknowledge pair. Read data returns in the same cycle as the acknowledge. Ownership is locked from first issue until acknowledge, so the bus address stays stable while a transaction is pending. Data requests take priority over instruction fetch. An optional fairness counter bounds instruction-fetch starvation.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive data grants, while fetch waits, before fetch is forced to win. Valid range 1–255.
- `clk` in 1: clock.
- `rstz` in 1: reset, asynchronous, active-low.
- `instr_addr` in 32: fetch address.
- `instr_req` in 1: fetch request.
- `instr_data` out 32: fetch read data; equals `mem_rdata`.
- `instr_gnt` out 1: fetch acknowledge; `instr_data` is valid in this cycle.
- `data_addr` in 32: load/store address.
- `data_wdata` in 32: store data.
- `data_mask` in 4: byte enables.
- `data_wr_en` in 1: 1 = store, 0 = load.
- `data_req` in 1: load/store request.
- `data_rdata` out 32: load data; equals `mem_rdata`.
- `data_ack` out 1: load/store acknowledge.
- `mem_addr` out 32: bus address.
- `mem_wdata` out 32: bus write data.
- `mem_mask` out 4: bus byte enables.
- `mem_wr_en` out 1: bus write enable.
- `mem_req` out 1: bus request.
- `mem_rdata` in 32: bus read data.
- `mem_ack` in 1: bus acknowledge; `mem_rdata` is valid in this cycle.

## Operation
- Owner FSM states: `IDLE`, `OWN_I`, `OWN_D`. Reset state is `IDLE`.
- In `IDLE`, selection is combinational:
  - If `data_req` is high and the fetch is not starved, data wins.
  - Otherwise `instr_req` wins.
  - The winner drives the bus in the same cycle, with no bubble.
- `IDLE` transitions:
  - Winner present and `mem_ack` = 1: stay in `IDLE`; the transaction completes in one cycle.
  - Winner present and `mem_ack` = 0: go to `OWN_I` or `OWN_D`.
- `OWN_x` behaviour:
  - The bus is muxed from requester x only, regardless of the other request.
  - `mem_ack` returns to `IDLE`.
  - If x drops its request before acknowledge, the transaction is abandoned and the FSM returns to `IDLE` next cycle. The memory tolerates request withdrawal.
- `mem_req` is the OR of the selected requester's request. It is 0 when nothing is selected.
- Unselected bus fields:
  - `mem_wr_en` = 0 whenever the instruction side is selected or nothing is selected.
  - `mem_wdata` and `mem_mask` are don't-care on instruction transactions; they are driven to 0.
- Acknowledge routing:
  - `instr_gnt` = `mem_ack` AND (instruction side selected).
  - `data_ack` = `mem_ack` AND (data side selected).
  - Never both at once.
- `instr_data` and `data_rdata` are both wired to `mem_rdata`. Each is meaningful only with its own acknowledge.
- Starvation counter (8-bit `starve_cnt`, saturating):
  - Increments on each data acknowledge while `instr_req` = 1.
  - Clears on an instruction acknowledge, or when `instr_req` = 0.
  - Fetch is starved when `starve_cnt` >= `STARVE_LIMIT`.

## Timing
- Reset values:
  - State `IDLE`, `starve_cnt` = 0.
  - All outputs are combinational from state and inputs. With no requests, `mem_req`, `mem_wr_en`, `instr_gnt` and `data_ack` are 0.
- Latency: zero added cycles. A request seen in `IDLE` appears on the bus in the same cycle.
- Back-to-back: acknowledge in cycle N with another request pending lets the next winner issue in cycle N+1.
- Simultaneous `instr_req` and `data_req` in `IDLE`: data wins unless the fetch is starved.
- Arrival of the other request during `OWN_x`: it waits. No preemption.
- Reset asserted mid-transaction: FSM forced to `IDLE` and counter cleared asynchronously. The pending transaction is dropped.

## Configuration
- `KRONOS_ARB_FAIRNESS_EN` defined: starvation counter present, behaviour as above.
- `KRONOS_ARB_FAIRNESS_EN` undefined: counter removed and `STARVE_LIMIT` ignored. Data has strict priority, so fetch can starve indefinitely.

## Structure
- Add `arb_owner_e` to `kronos_types`: `IDLE`, `OWN_I`, `OWN_D`, 2 bits.
- Add `ARB_STARVE_W` = 8 to `kronos_types`.
- Single module. No sub-module; the selection mux is inline.

## Test plan
- Fetch only: `instr_req`=1, `instr_addr`=0x100, `mem_ack` in the same cycle -> `mem_addr`=0x100, `instr_gnt`=1, `instr_data`=`mem_rdata`=0xDEADBEEF, state remains `IDLE`.
- Conflict: both requests in `IDLE`, `data_addr`=0x2000, store, `mem_ack` delayed 2 cycles -> `mem_wr_en`=1 and `mem_addr`=0x2000 held for 3 cycles, then `data_ack`=1. The fetch issues the next cycle.
- Lock: fetch owns the bus with `mem_ack` delayed 3 cycles, `data_req` rises in cycle 1 -> `mem_addr` stays at `instr_addr` until `instr_gnt`. Data issues in the following cycle.
- Withdrawal: in `OWN_I`, `instr_req` drops before ack -> `IDLE` next cycle, no `instr_gnt`, and a pending data request issues.
- Fairness (macro on, `STARVE_LIMIT`=4): continuous `data_req` and `instr_req`, ack every cycle -> 4 `data_ack`s, then 1 `instr_gnt`, repeating. With the macro off -> `instr_gnt` never asserts.
- Reset: assert `rstz`=0 during `OWN_D` -> `mem_req`=0, `data_ack`=0, and after release the state is `IDLE` with the counter at 0.
